pwm_ramp: RTL and testbench
===========================

# pwm_ramp

Duty-cycle ramp sequencer that sits directly upstream of the `pwm` peripheral and drives its register-write port (`wen`/`addr`/`wdata`). The host writes a small configuration set once. The block then programs the PWM period, enables the PWM, and steps the duty register from a start value to an end value at a fixed dwell rate, either once or as a continuous triangle. This offloads LED fades and motor soft-starts from the CPU.

## Interface
- `DWELL_W`, default 8: width of the dwell register and counter.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `wen`  in  1  host config write strobe, one cycle.
- `addr`  in  4  host config address.
- `wdata`  in  8  host config data.
- `pwm_wen`  out  1  write strobe to `pwm`, one-cycle pulse.
- `pwm_addr`  out  4  `pwm` register address: 0x0 period, 0x4 duty, 0x8 enable.
- `pwm_wdata`  out  8  `pwm` register data.
- `busy`  out  1  high while a ramp is running.
- `done`  out  1  one-cycle pulse when a one-shot ramp completes.

## Operation
- Config registers, all reset to 0:
  - 0x0 PERIOD
  - 0x1 START
  - 0x2 END
  - 0x3 STEP (0 is treated as 1)
  - 0x4 DWELL (width `DWELL_W`; upper `wdata` bits above `DWELL_W` are ignored)
  - 0x5 CTRL, write-only strobes: bit0 GO, bit1 TRI (level, stored), bit2 STOP
- Writes to other addresses are ignored.
- GO in IDLE snapshots PERIOD/START/END/STEP/DWELL/TRI into working copies. Config writes while busy affect only the next run.
- GO while busy is ignored. STOP and GO in the same write: STOP wins.
- States: IDLE, W_PER, W_DUTY0, W_EN, DWELL, W_DUTY, W_DIS. Each W_* state lasts exactly one cycle and asserts `pwm_wen`.
- Writes emitted by each state:
  - W_PER: addr 0x0, data PERIOD
  - W_DUTY0: addr 0x4, data START
  - W_EN: addr 0x8, data 0x01
  - W_DUTY: addr 0x4, data next duty
  - W_DIS: addr 0x8, data 0x00
- Transitions:
  - IDLE -GO-> W_PER -> W_DUTY0 -> W_EN.
  - W_EN -> DWELL, unless cur==target and TRI=0, in which case -> IDLE with `done` pulse.
  - DWELL runs DWELL+1 cycles -> W_DUTY.
  - W_DUTY -> DWELL, unless the written duty == target and TRI=0, in which case -> IDLE with `done` pulse.
- Direction is up if target >= cur, else down. Initial target is END.
- Next duty, all arithmetic 9-bit:
  - Up: cur+STEP, clamped to target if the result exceeds target or 255.
  - Down: cur−STEP, clamped to target if the result is below target or underflows.
- TRI=1: when the written duty equals target, target swaps between END and START and the ramp continues indefinitely.
- TRI=1 with START==END: the block stays in the DWELL / W_DUTY loop, rewriting the same value.
- STOP, whether busy or idle, forces W_DIS on the next cycle, then IDLE. No `done` pulse.
- After a one-shot completion the PWM stays enabled at duty END.
- `busy` = state != IDLE.

## Timing
- Reset values: `pwm_wen`=0, `pwm_addr`=0, `pwm_wdata`=0, `busy`=0, `done`=0; state IDLE; working copies 0.
- Reset mid-ramp aborts immediately with no W_DIS write; `pwm` shares `rst`.
- Outputs are registered. `pwm_addr` and `pwm_wdata` are valid only when `pwm_wen`=1 and read 0 otherwise.
- Start-up timing, with GO sampled at edge T:
  - W_PER at cycle T+1, W_DUTY0 at T+2, W_EN at T+3.
  - First DWELL at T+4 … T+4+DWELL.
  - First W_DUTY at T+5+DWELL.
- Consecutive duty writes are DWELL+2 cycles apart.
- Completion: `done` is high in the cycle after the final W_EN or W_DUTY; `busy` is low in that same cycle.
- STOP sampled at edge T gives W_DIS at cycle T+1 regardless of the current state; a write already in progress at cycle T completes.

## Test plan
- One-shot up ramp. Config: PERIOD=100, START=10, END=40, STEP=10, DWELL=3, GO.
  - Writes: (0x0,100), (0x4,10), (0x8,1), then duty 20, 30, 40, each 5 cycles apart.
  - `done` pulses once, cycle after the 40 write; `busy` falls in that cycle.
- Clamp on both directions.
  - START=0, END=25, STEP=10: duty writes 10, 20, 25.
  - START=250, END=3, STEP=100: duty writes 150, 50, 3 (no underflow).
- Triangle, TRI=1, START=0, END=20, STEP=10, DWELL=0: duty sequence 10, 20, 10, 0, 10, …, writes 2 cycles apart.
  - STOP mid-ramp → (0x8,0) exactly 1 cycle after the STOP write, then `busy`=0 and no `done`.
- START==END=50 one-shot: exactly three writes (period, 50, enable), then `done`; no DWELL cycles.
- GO while busy is ignored. Config write of END=90 mid-run does not change the current run. Reset asserted mid-DWELL: all outputs 0 the next cycle and no further `pwm_wen`.

Source files
------------

// File: rtl/pwm_ramp.sv
// Duty-cycle ramp sequencer driving the register-write port of a downstream pwm block.
// Programs period, enables, then steps duty START->END (one-shot) or bounces between them.
module pwm_ramp #(
    parameter int DWELL_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wen,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       pwm_wen,
    output logic [3:0] pwm_addr,
    output logic [7:0] pwm_wdata,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {
        S_IDLE, S_W_PER, S_W_DUTY0, S_W_EN, S_DWELL, S_W_DUTY, S_W_DIS
    } state_t;

    localparam logic [3:0] PWM_PER  = 4'h0;
    localparam logic [3:0] PWM_DUTY = 4'h4;
    localparam logic [3:0] PWM_EN   = 4'h8;

    state_t               state_q, state_d;
    logic [7:0]           cfg_period_q, cfg_period_d;
    logic [7:0]           cfg_start_q, cfg_start_d;
    logic [7:0]           cfg_end_q, cfg_end_d;
    logic [7:0]           cfg_step_q, cfg_step_d;
    logic [DWELL_W-1:0]   cfg_dwell_q, cfg_dwell_d;
    logic                 cfg_tri_q, cfg_tri_d;
    logic [7:0]           start_q, start_d;
    logic [7:0]           end_q, end_d;
    logic [7:0]           step_q, step_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 tri_q, tri_d;
    logic [7:0]           cur_q, cur_d;
    logic                 to_end_q, to_end_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 pwm_wen_q, pwm_wen_d;
    logic [3:0]           pwm_addr_q, pwm_addr_d;
    logic [7:0]           pwm_wdata_q, pwm_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 ctrl_wr, go, stop;
    logic [7:0]           target, nxt;

    // Step toward tgt in 9-bit arithmetic, clamping on overshoot, overflow or underflow.
    function automatic logic [7:0] next_duty(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (tgt >= cur)
            next_duty = (sum > {1'b0, tgt}) ? tgt : sum[7:0];
        else
            next_duty = (diff[8] || (diff[7:0] < tgt)) ? tgt : diff[7:0];
    endfunction

    assign ctrl_wr = wen && (addr == 4'h5);
    assign stop    = ctrl_wr && wdata[2];
    assign go      = ctrl_wr && wdata[0] && !wdata[2];
    assign target  = to_end_q ? end_q : start_q;
    assign nxt     = next_duty(cur_q, target, step_q);

    always_comb begin
        state_d      = state_q;
        cfg_period_d = cfg_period_q;
        cfg_start_d  = cfg_start_q;
        cfg_end_d    = cfg_end_q;
        cfg_step_d   = cfg_step_q;
        cfg_dwell_d  = cfg_dwell_q;
        cfg_tri_d    = cfg_tri_q;
        start_d      = start_q;
        end_d        = end_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        tri_d        = tri_q;
        cur_d        = cur_q;
        to_end_d     = to_end_q;
        cnt_d        = cnt_q;
        pwm_wen_d    = 1'b0;
        pwm_addr_d   = 4'h0;
        pwm_wdata_d  = 8'h00;
        done_d       = 1'b0;

        if (wen) begin
            case (addr)
                4'h0: cfg_period_d = wdata;
                4'h1: cfg_start_d  = wdata;
                4'h2: cfg_end_d    = wdata;
                4'h3: cfg_step_d   = wdata;
                4'h4: cfg_dwell_d  = DWELL_W'(wdata);
                4'h5: cfg_tri_d    = wdata[1];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    // TRI written alongside GO applies to this run.
                    start_d     = cfg_start_q;
                    end_d       = cfg_end_q;
                    step_d      = (cfg_step_q == 8'd0) ? 8'd1 : cfg_step_q;
                    dwell_d     = cfg_dwell_q;
                    tri_d       = wdata[1];
                    to_end_d    = 1'b1;
                    state_d     = S_W_PER;
                    pwm_wen_d   = 1'b1;
                    pwm_addr_d  = PWM_PER;
                    pwm_wdata_d = cfg_period_q;
                end
            end
            S_W_PER: begin
                cur_d       = start_q;
                state_d     = S_W_DUTY0;
                pwm_wen_d   = 1'b1;
                pwm_addr_d  = PWM_DUTY;
                pwm_wdata_d = start_q;
            end
            S_W_DUTY0: begin
                state_d     = S_W_EN;
                pwm_wen_d   = 1'b1;
                pwm_addr_d  = PWM_EN;
                pwm_wdata_d = 8'h01;
            end
            S_W_EN: begin
                cnt_d = '0;
                if (cur_q == target && !tri_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt_q == dwell_q) begin
                    cur_d       = nxt;
                    state_d     = S_W_DUTY;
                    pwm_wen_d   = 1'b1;
                    pwm_addr_d  = PWM_DUTY;
                    pwm_wdata_d = nxt;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_W_DUTY: begin
                cnt_d = '0;
                if (cur_q == target && !tri_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (cur_q == target)
                        to_end_d = !to_end_q;
                    state_d = S_DWELL;
                end
            end
            S_W_DIS: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // STOP overrides whatever the current state decided, including a pending done.
        if (stop) begin
            state_d     = S_W_DIS;
            pwm_wen_d   = 1'b1;
            pwm_addr_d  = PWM_EN;
            pwm_wdata_d = 8'h00;
            done_d      = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cfg_period_q <= '0;
            cfg_start_q  <= '0;
            cfg_end_q    <= '0;
            cfg_step_q   <= '0;
            cfg_dwell_q  <= '0;
            cfg_tri_q    <= 1'b0;
            start_q      <= '0;
            end_q        <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            tri_q        <= 1'b0;
            cur_q        <= '0;
            to_end_q     <= 1'b0;
            cnt_q        <= '0;
            pwm_wen_q    <= 1'b0;
            pwm_addr_q   <= '0;
            pwm_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_period_q <= cfg_period_d;
            cfg_start_q  <= cfg_start_d;
            cfg_end_q    <= cfg_end_d;
            cfg_step_q   <= cfg_step_d;
            cfg_dwell_q  <= cfg_dwell_d;
            cfg_tri_q    <= cfg_tri_d;
            start_q      <= start_d;
            end_q        <= end_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            tri_q        <= tri_d;
            cur_q        <= cur_d;
            to_end_q     <= to_end_d;
            cnt_q        <= cnt_d;
            pwm_wen_q    <= pwm_wen_d;
            pwm_addr_q   <= pwm_addr_d;
            pwm_wdata_q  <= pwm_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pwm_wen   = pwm_wen_q;
    assign pwm_addr  = pwm_addr_q;
    assign pwm_wdata = pwm_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp.sv
// Self-checking bench for pwm_ramp: a monitor logs every pwm write and done pulse,
// and each scenario compares that log against a write list built from the ramp rules.
module tb_pwm_ramp;
    localparam int DWELL_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] wdata = 8'h00;
    logic       pwm_wen;
    logic [3:0] pwm_addr;
    logic [7:0] pwm_wdata;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int idle_junk = 0;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_q[$];
    int  done_busy_q[$];

    pwm_ramp #(.DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .wen(wen), .addr(addr), .wdata(wdata),
        .pwm_wen(pwm_wen), .pwm_addr(pwm_addr), .pwm_wdata(pwm_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A write seen with cyc==N was launched by the posedge that set cyc to N.
    always @(negedge clk) begin : mon
        wr_t w;
        if (pwm_wen === 1'b1) begin
            w.c = cyc;
            w.a = int'(pwm_addr);
            w.d = int'(pwm_wdata);
            got_q.push_back(w);
        end else if (pwm_addr !== 4'h0 || pwm_wdata !== 8'h00) begin
            idle_junk++;
        end
        if (done === 1'b1) begin
            done_q.push_back(cyc);
            done_busy_q.push_back(int'(busy));
        end
    end

    task automatic host_wr(input int a, input int d);
        @(negedge clk);
        wen = 1'b1; addr = a[3:0]; wdata = d[7:0];
        @(negedge clk);
        wen = 1'b0; addr = 4'h0; wdata = 8'h00;
    endtask

    task automatic configure(input int p, input int s, input int e, input int st, input int dw);
        host_wr(0, p); host_wr(1, s); host_wr(2, e); host_wr(3, st); host_wr(4, dw);
    endtask

    task automatic push_exp(input int c, input int a, input int d);
        wr_t w;
        w.c = c; w.a = a; w.d = d;
        exp_q.push_back(w);
    endtask

    // Plain-integer step toward tgt, clamped so it never passes tgt.
    function automatic int step_toward(input int cur, input int tgt, input int stp);
        if (tgt >= cur) return (cur + stp > tgt) ? tgt : cur + stp;
        return (cur - stp < tgt) ? tgt : cur - stp;
    endfunction

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000; i++) begin
            if (busy !== 1'b1) break;
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pwm_wen !== 1'b0)     begin bad++; $display("FAIL reset_pwm_wen got=%b exp=0", pwm_wen); end
        total++; if (pwm_addr !== 4'h0)    begin bad++; $display("FAIL reset_pwm_addr got=%h exp=0", pwm_addr); end
        total++; if (pwm_wdata !== 8'h00)  begin bad++; $display("FAIL reset_pwm_wdata got=%h exp=0", pwm_wdata); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oneshot(input string name, input int p, input int s, input int e,
                                input int st, input int dw, input bit disturb);
        int g, t, cur, stp, exp_done, n;
        configure(p, s, e, st, dw);
        got_q.delete(); done_q.delete(); done_busy_q.delete(); exp_q.delete();
        host_wr(5, 1);
        g = cyc;
        if (disturb) begin
            repeat (4) @(negedge clk);
            host_wr(5, 1);
            host_wr(2, 90);
        end
        wait_idle(name);
        repeat (4) @(negedge clk);

        push_exp(g, 0, p); push_exp(g + 1, 4, s); push_exp(g + 2, 8, 1);
        stp = (st == 0) ? 1 : st;
        cur = s;
        t = g + 2;
        while (cur != e) begin
            cur = step_toward(cur, e, stp);
            t += dw + 2;
            push_exp(t, 4, cur);
        end
        exp_done = t + 1;

        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[i].c != exp_q[i].c || got_q[i].a != exp_q[i].a || got_q[i].d != exp_q[i].d) begin
                bad++;
                $display("FAIL %s write%0d got=(cyc %0d,a %0h,d %0d) exp=(cyc %0d,a %0h,d %0d)", name, i,
                         got_q[i].c, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
        total++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            bad++;
            $display("FAIL %s done pulses=%0d first_cyc=%0d exp one at %0d", name, done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        end
        total++;
        if (done_busy_q.size() < 1 || done_busy_q[0] != 0) begin
            bad++;
            $display("FAIL %s busy_at_done got=%0d exp=0", name,
                     (done_busy_q.size() > 0) ? done_busy_q[0] : -1);
        end
    endtask

    task automatic test_random_oneshot();
        for (int k = 0; k < 5; k++)
            test_oneshot("rand_oneshot", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 60)),
                         int'($urandom_range(0, 4)), 1'b0);
    endtask

    task automatic test_triangle(input string name, input int s, input int e, input int st,
                                 input int dw, input int run_cycles);
        int g, ts, t, cur, tgt, n;
        bit to_end;
        configure(40, s, e, st, dw);
        got_q.delete(); done_q.delete(); done_busy_q.delete(); exp_q.delete();
        host_wr(5, 3);
        g = cyc;
        repeat (run_cycles) @(negedge clk);
        host_wr(5, 4);
        ts = cyc;
        repeat (3) @(negedge clk);

        push_exp(g, 0, 40); push_exp(g + 1, 4, s); push_exp(g + 2, 8, 1);
        cur = s; to_end = 1'b1; t = g + 2;
        forever begin
            t += dw + 2;
            if (t >= ts) break;
            tgt = to_end ? e : s;
            cur = step_toward(cur, tgt, (st == 0) ? 1 : st);
            push_exp(t, 4, cur);
            if (cur == tgt) to_end = !to_end;
        end
        push_exp(ts, 8, 0);

        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[i].c != exp_q[i].c || got_q[i].a != exp_q[i].a || got_q[i].d != exp_q[i].d) begin
                bad++;
                $display("FAIL %s write%0d got=(cyc %0d,a %0h,d %0d) exp=(cyc %0d,a %0h,d %0d)", name, i,
                         got_q[i].c, got_q[i].a, got_q[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
            end
        end
        total++;
        if (done_q.size() != 0) begin
            bad++;
            $display("FAIL %s done_after_stop got=%0d pulses exp=0", name, done_q.size());
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after_stop got=%b exp=0", name, busy);
        end
    endtask

    task automatic test_stop_idle();
        int ts;
        got_q.delete(); done_q.delete();
        host_wr(5, 4);
        ts = cyc;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL stop_idle busy_in_wdis got=%b exp=1", busy); end
        repeat (3) @(negedge clk);
        total++;
        if (got_q.size() != 1 || got_q[0].c != ts || got_q[0].a != 8 || got_q[0].d != 0) begin
            bad++;
            $display("FAIL stop_idle writes=%0d first=(cyc %0d,a %0h,d %0d) exp one (cyc %0d,a 8,d 0)",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].c : -1,
                     (got_q.size() > 0) ? got_q[0].a : -1, (got_q.size() > 0) ? got_q[0].d : -1, ts);
        end
        total++;
        if (busy !== 1'b0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL stop_idle end busy=%b done_pulses=%0d exp busy=0 pulses=0", busy, done_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        configure(100, 10, 40, 10, 8);
        got_q.delete(); done_q.delete();
        host_wr(5, 1);
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1 || got_q.size() != 3) begin
            bad++;
            $display("FAIL reset_mid precondition busy=%b writes=%0d exp busy=1 writes=3", busy, got_q.size());
        end
        rst = 1'b1;
        @(negedge clk);
        n0 = got_q.size();
        total++;
        if ({pwm_wen, pwm_addr, pwm_wdata, busy, done} !== 15'h0) begin
            bad++;
            $display("FAIL reset_mid outputs got wen=%b addr=%h data=%h busy=%b done=%b exp all 0",
                     pwm_wen, pwm_addr, pwm_wdata, busy, done);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (got_q.size() != n0 || done_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid aftermath new_writes=%0d done=%0d busy=%b exp 0 0 0",
                     got_q.size() - n0, done_q.size(), busy);
        end
    endtask

    task automatic test_idle_outputs();
        total++;
        if (idle_junk != 0) begin
            bad++;
            $display("FAIL idle_addr_data nonzero_cycles=%0d exp=0", idle_junk);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot("oneshot_up", 100, 10, 40, 10, 3, 1'b0);
        test_oneshot("clamp_up", 60, 0, 25, 10, 2, 1'b0);
        test_oneshot("clamp_down", 60, 250, 3, 100, 1, 1'b0);
        test_oneshot("start_eq_end", 77, 50, 50, 7, 4, 1'b0);
        test_oneshot("step_zero", 30, 5, 9, 0, 0, 1'b0);
        test_oneshot("go_busy_cfg", 100, 10, 40, 10, 6, 1'b1);
        test_random_oneshot();
        test_triangle("tri_basic", 0, 20, 10, 0, 20);
        test_triangle("tri_equal", 50, 50, 5, 1, 15);
        for (int k = 0; k < 3; k++)
            test_triangle("tri_rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(1, 90)), int'($urandom_range(0, 3)), 60);
        test_stop_idle();
        test_reset_mid();
        test_idle_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
